// File: rtl/aq_djpeg_sched_pkg.sv
// Shared state encoding and the MCU-count helper for the JPEG MCU scheduler.
package aq_djpeg_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } schedState_t;

    // MCUs covering one dimension: 16-pixel MCUs when the factor is 2, otherwise 8.
    function automatic logic [31:0] mcuCount(input logic [31:0] dim, input logic [1:0] factor);
        logic [31:0] sum;
        if (factor == 2'd2) begin
            sum = dim + 32'd15;
            return {4'b0, sum[31:4]};
        end
        sum = dim + 32'd7;
        return {3'b0, sum[31:3]};
    endfunction

endpackage

// File: rtl/aq_djpeg_pingpong_ctl.sv
// Ping-pong MCU buffer bookkeeping: per-bank valid flags plus write/read bank pointers.
module aq_djpeg_pingpong_ctl
    import aq_djpeg_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       setValid,
    input  logic       clrValid,
    output logic [1:0] valid,
    output logic       wrBank,
    output logic       rdBank
);

    logic [1:0] validNext;

    // set and clear can coincide; they always target different banks
    always_comb begin
        validNext = valid;
        if (setValid) validNext[wrBank] = 1'b1;
        if (clrValid) validNext[rdBank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 2'b00;
            wrBank <= 1'b0;
            rdBank <= 1'b0;
        end else if (clear) begin
            valid  <= 2'b00;
            wrBank <= 1'b0;
            rdBank <= 1'b0;
        end else begin
            valid <= validNext;
            if (setValid) wrBank <= ~wrBank;
            if (clrValid) rdBank <= ~rdBank;
        end
    end

endmodule

// File: rtl/aq_djpeg_mcu_sched.sv
// MCU scheduler between IDCT/upsample writer and colour converter; optional stall
// statistics are enabled by defining AQ_DJPEG_MCU_SCHED_STATS_EN.
//   state | meaning
//   IDLE  | waiting for FrameStart
//   WAIT  | waiting for the read bank to hold an MCU
//   ISSUE | one-cycle converter start pulse
//   RUN   | converter busy until ConvDone
//   DONE  | one-cycle frame-complete pulse
module aq_djpeg_mcu_sched
    import aq_djpeg_sched_pkg::*;
#(
    parameter int BW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          DataInit,
    input  logic          FrameStart,
    input  logic [DW-1:0] ImageWidth,
    input  logic [DW-1:0] ImageHeight,
    input  logic [1:0]    SubSamplingW,
    input  logic [1:0]    SubSamplingH,
    input  logic          McuDone,
    output logic          WrBank,
    output logic          WrReady,
    output logic          ConvEnable,
    output logic          ConvBank,
    output logic [BW-1:0] ConvBlockX,
    output logic [BW-1:0] ConvBlockY,
    input  logic          ConvDone,
    output logic          Busy,
    output logic          FrameDone,
    output logic          Overrun
`ifdef AQ_DJPEG_MCU_SCHED_STATS_EN
    ,
    output logic [31:0]   StallCycles,
    output logic [31:0]   BlockedCycles
`endif
);

    schedState_t   state, stateNext;
    logic [DW-1:0] latWidth, latHeight;
    logic [1:0]    latSampW, latSampH;
    logic [BW-1:0] mcuCols, mcuRows;
    logic [1:0]    valid;
    logic          rdBank;
    logic          setValid, clrValid, lastX, lastY, frameAccept;

    assign mcuCols     = BW'(mcuCount(32'(latWidth), latSampW));
    assign mcuRows     = BW'(mcuCount(32'(latHeight), latSampH));
    assign Busy        = (state != S_IDLE);
    assign WrReady     = Busy & ~valid[WrBank];
    assign setValid    = McuDone & WrReady;
    assign clrValid    = (state == S_RUN) & ConvDone;
    assign lastX       = (ConvBlockX == mcuCols - BW'(1));
    assign lastY       = (ConvBlockY == mcuRows - BW'(1));
    assign frameAccept = (state == S_IDLE) & FrameStart;
    assign ConvEnable  = (state == S_ISSUE);
    assign FrameDone   = (state == S_DONE);
    assign ConvBank    = rdBank;

    aq_djpeg_pingpong_ctl uPingPong (
        .clk      (clk),
        .rst      (rst),
        .clear    (DataInit),
        .setValid (setValid),
        .clrValid (clrValid),
        .valid    (valid),
        .wrBank   (WrBank),
        .rdBank   (rdBank)
    );

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (FrameStart) stateNext = S_WAIT;
            S_WAIT:  if (valid[rdBank]) stateNext = S_ISSUE;
            S_ISSUE: stateNext = S_RUN;
            S_RUN:   if (ConvDone) stateNext = (lastX && lastY) ? S_DONE : S_WAIT;
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
        if (DataInit) stateNext = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latWidth   <= '0;
            latHeight  <= '0;
            latSampW   <= 2'd0;
            latSampH   <= 2'd0;
            ConvBlockX <= '0;
            ConvBlockY <= '0;
            Overrun    <= 1'b0;
        end else if (DataInit) begin
            latWidth   <= '0;
            latHeight  <= '0;
            latSampW   <= 2'd0;
            latSampH   <= 2'd0;
            ConvBlockX <= '0;
            ConvBlockY <= '0;
            Overrun    <= 1'b0;
        end else begin
            if (frameAccept) begin
                latWidth  <= ImageWidth;
                latHeight <= ImageHeight;
                latSampW  <= SubSamplingW;
                latSampH  <= SubSamplingH;
            end
            // the last MCU keeps its coordinates through DONE, then they return to 0
            if (clrValid && !(lastX && lastY)) begin
                if (lastX) begin
                    ConvBlockX <= '0;
                    ConvBlockY <= ConvBlockY + BW'(1);
                end else begin
                    ConvBlockX <= ConvBlockX + BW'(1);
                end
            end
            if (state == S_DONE) begin
                ConvBlockX <= '0;
                ConvBlockY <= '0;
            end
            if (McuDone && Busy && !WrReady) Overrun <= 1'b1;
        end
    end

`ifdef AQ_DJPEG_MCU_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCycles   <= '0;
            BlockedCycles <= '0;
        end else if (DataInit || frameAccept) begin
            StallCycles   <= '0;
            BlockedCycles <= '0;
        end else begin
            if ((state == S_WAIT) && !valid[rdBank] && (StallCycles != '1))
                StallCycles <= StallCycles + 32'd1;
            if (Busy && !WrReady && (BlockedCycles != '1))
                BlockedCycles <= BlockedCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aq_djpeg_mcu_sched.sv
// Directed bench for aq_djpeg_mcu_sched with a transaction-level occupancy model.
module tb_aq_djpeg_mcu_sched;

    localparam int BW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          DataInit = 1'b0;
    logic          FrameStart = 1'b0;
    logic [DW-1:0] ImageWidth = '0;
    logic [DW-1:0] ImageHeight = '0;
    logic [1:0]    SubSamplingW = 2'd1;
    logic [1:0]    SubSamplingH = 2'd1;
    logic          McuDone = 1'b0;
    logic          autoDone = 1'b0;
    logic          manDone = 1'b0;
    logic          ConvDone;
    logic          WrBank, WrReady, ConvEnable, ConvBank, Busy, FrameDone, Overrun;
    logic [BW-1:0] ConvBlockX, ConvBlockY;
`ifdef AQ_DJPEG_MCU_SCHED_STATS_EN
    logic [31:0]   StallCycles, BlockedCycles;
`endif

    assign ConvDone = autoDone | manDone;

    aq_djpeg_mcu_sched #(.BW(BW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .DataInit     (DataInit),
        .FrameStart   (FrameStart),
        .ImageWidth   (ImageWidth),
        .ImageHeight  (ImageHeight),
        .SubSamplingW (SubSamplingW),
        .SubSamplingH (SubSamplingH),
        .McuDone      (McuDone),
        .WrBank       (WrBank),
        .WrReady      (WrReady),
        .ConvEnable   (ConvEnable),
        .ConvBank     (ConvBank),
        .ConvBlockX   (ConvBlockX),
        .ConvBlockY   (ConvBlockY),
        .ConvDone     (ConvDone),
        .Busy         (Busy),
        .FrameDone    (FrameDone),
        .Overrun      (Overrun)
`ifdef AQ_DJPEG_MCU_SCHED_STATS_EN
        ,
        .StallCycles  (StallCycles),
        .BlockedCycles(BlockedCycles)
`endif
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nFail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            if (nFail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        nCmp++;
        nFail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Model: MCUs counted in and out; banks are the parity of those counts,
    // coordinates follow from how many MCUs of the frame have been consumed.
    int mBusy = 0, mWaiting = 0, mIssue = 0, mRun = 0, mDone = 0, mOvr = 0;
    int wrTot = 0, rdTot = 0, nCons = 0, cols = 0, rows = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst || DataInit) begin
            mBusy = 0; mWaiting = 0; mIssue = 0; mRun = 0; mDone = 0; mOvr = 0;
            wrTot = 0; rdTot = 0; nCons = 0; cols = 0; rows = 0;
        end else begin
            int occ, pWaiting, pIssue, pRun, pDone, pBusy, rdy, mcuW, mcuH;
            occ = wrTot - rdTot;
            pWaiting = mWaiting; pIssue = mIssue; pRun = mRun; pDone = mDone; pBusy = mBusy;
            rdy = (pBusy != 0) && (occ < 2);
            mIssue   = (pWaiting != 0) && (occ > 0);
            mWaiting = (pWaiting != 0) && (occ == 0);
            mRun     = (pIssue != 0) || ((pRun != 0) && !ConvDone);
            mDone    = 0;
            if (pRun != 0 && ConvDone) begin
                rdTot++;
                nCons++;
                if (nCons == cols * rows) mDone = 1;
                else mWaiting = 1;
            end
            if (pDone != 0) begin
                mBusy = 0;
                nCons = 0;
            end
            if (McuDone && pBusy != 0) begin
                if (rdy) wrTot++;
                else mOvr = 1;
            end
            if (pBusy == 0 && FrameStart) begin
                mcuW = (SubSamplingW == 2'd2) ? 16 : 8;
                mcuH = (SubSamplingH == 2'd2) ? 16 : 8;
                cols = (int'(ImageWidth) + mcuW - 1) / mcuW;
                rows = (int'(ImageHeight) + mcuH - 1) / mcuH;
                mBusy = 1;
                mWaiting = 1;
                nCons = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            int expX, expY;
            if (mDone != 0) begin
                expX = cols - 1;
                expY = rows - 1;
            end else if (cols == 0) begin
                expX = 0;
                expY = 0;
            end else begin
                expX = nCons % cols;
                expY = nCons / cols;
            end
            check("Busy", longint'(Busy), mBusy);
            check("WrReady", longint'(WrReady), ((mBusy != 0) && (wrTot - rdTot < 2)) ? 1 : 0);
            check("WrBank", longint'(WrBank), wrTot % 2);
            check("ConvBank", longint'(ConvBank), rdTot % 2);
            check("ConvEnable", longint'(ConvEnable), mIssue);
            check("FrameDone", longint'(FrameDone), mDone);
            check("Overrun", longint'(Overrun), mOvr);
            check("ConvBlockX", longint'(ConvBlockX), expX);
            check("ConvBlockY", longint'(ConvBlockY), expY);
        end
    end

    typedef struct {
        int x;
        int y;
        int b;
    } ev_t;
    ev_t evQ[$];
    int  fdCount = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (ConvEnable) evQ.push_back('{int'(ConvBlockX), int'(ConvBlockY), int'(ConvBank)});
            if (FrameDone) fdCount++;
        end
    end

    // Converter stand-in: ConvDone convDelay cycles after each start pulse (0 = withheld).
    int convDelay = 0;
    int convCnt = 0;
    initial forever begin
        @(negedge clk);
        autoDone = 1'b0;
        if (convCnt > 0) begin
            convCnt--;
            if (convCnt == 0) autoDone = 1'b1;
        end
        if (ConvEnable && convDelay > 0) convCnt = convDelay;
    end

    task automatic pulseInit();
        DataInit = 1'b1;
        @(negedge clk);
        DataInit = 1'b0;
        @(negedge clk);
    endtask

    task automatic startFrame(input int w, input int h, input int sw, input int sh);
        ImageWidth   = 16'(w);
        ImageHeight  = 16'(h);
        SubSamplingW = 2'(sw);
        SubSamplingH = 2'(sh);
        FrameStart   = 1'b1;
        @(negedge clk);
        FrameStart   = 1'b0;
    endtask

    task automatic mcu();
        McuDone = 1'b1;
        @(negedge clk);
        McuDone = 1'b0;
    endtask

    task automatic waitEv(input int n, input int maxc, input string name);
        int c = 0;
        while (evQ.size() < n && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (evQ.size() < n) timeoutFail(name);
    endtask

    task automatic waitFd(input int n, input int maxc, input string name);
        int c = 0;
        while (fdCount < n && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (fdCount < n) timeoutFail(name);
    endtask

    task automatic waitReady(input int maxc, input string name);
        int c = 0;
        while (!WrReady && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (!WrReady) timeoutFail(name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ex[6];
        int ey[6];
        ex = '{0, 1, 2, 0, 1, 2};
        ey = '{0, 0, 0, 1, 1, 1};

        repeat (3) @(negedge clk);
        check("rst_Busy", longint'(Busy), 0);
        check("rst_WrReady", longint'(WrReady), 0);
        check("rst_ConvEnable", longint'(ConvEnable), 0);
        check("rst_FrameDone", longint'(FrameDone), 0);
        check("rst_Overrun", longint'(Overrun), 0);
        check("rst_WrBank", longint'(WrBank), 0);
        check("rst_ConvBank", longint'(ConvBank), 0);
        check("rst_XY", longint'({ConvBlockX, ConvBlockY}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 32x16 with 2x2 sampling: two MCUs side by side
        pulseInit();
        evQ.delete();
        fdCount = 0;
        convDelay = 256;
        startFrame(32, 16, 2, 2);
        mcu();
        repeat (299) @(negedge clk);
        mcu();
        waitFd(1, 1000, "t1_framedone");
        repeat (2) @(negedge clk);
        check("t1_evcount", evQ.size(), 2);
        if (evQ.size() == 2) begin
            check("t1_ev0", evQ[0].x * 100 + evQ[0].y * 10 + evQ[0].b, 0);
            check("t1_ev1", evQ[1].x * 100 + evQ[1].y * 10 + evQ[1].b, 101);
        end
        check("t1_fdcount", fdCount, 1);
        check("t1_busy_after", longint'(Busy), 0);

        // 24x8: producer runs ahead with the converter stalled
        pulseInit();
        convDelay = 0;
        startFrame(24, 8, 1, 1);
        McuDone = 1'b1;
        @(negedge clk);
        check("t2_ready_after1", longint'(WrReady), 1);
        @(negedge clk);
        check("t2_ready_after2", longint'(WrReady), 0);
        @(negedge clk);
        McuDone = 1'b0;
        check("t2_overrun", longint'(Overrun), 1);
        check("t2_wrbank", longint'(WrBank), 0);
        pulseInit();
        check("t2_overrun_cleared", longint'(Overrun), 0);

        // 17x9: 3x2 MCUs in raster order
        evQ.delete();
        fdCount = 0;
        convDelay = 5;
        startFrame(17, 9, 1, 1);
        for (int i = 0; i < 6; i++) begin
            waitReady(200, "t3_wrready");
            mcu();
        end
        waitFd(1, 2000, "t3_framedone");
        repeat (2) @(negedge clk);
        check("t3_evcount", evQ.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < evQ.size()) begin
                check("t3_x", evQ[i].x, ex[i]);
                check("t3_y", evQ[i].y, ey[i]);
                check("t3_bank", evQ[i].b, i % 2);
            end
        end
        check("t3_fdcount", fdCount, 1);
        convDelay = 0;

        // McuDone and ConvDone in the same cycle
        pulseInit();
        evQ.delete();
        startFrame(24, 8, 1, 1);
        mcu();
        waitEv(1, 20, "t4_first_enable");
        repeat (3) @(negedge clk);
        McuDone = 1'b1;
        manDone = 1'b1;
        @(negedge clk);
        McuDone = 1'b0;
        manDone = 1'b0;
        check("t4_enable_gap", longint'(ConvEnable), 0);
        check("t4_wrready", longint'(WrReady), 1);
        check("t4_wrbank", longint'(WrBank), 0);
        check("t4_convbank", longint'(ConvBank), 1);
        @(negedge clk);
        check("t4_enable", longint'(ConvEnable), 1);
        check("t4_x", longint'(ConvBlockX), 1);
        check("t4_y", longint'(ConvBlockY), 0);

        // DataInit while the converter is running
        pulseInit();
        evQ.delete();
        startFrame(8, 8, 1, 1);
        mcu();
        waitEv(1, 20, "t5_enable");
        repeat (2) @(negedge clk);
        DataInit = 1'b1;
        @(negedge clk);
        DataInit = 1'b0;
        check("t5_busy", longint'(Busy), 0);
        check("t5_wrbank", longint'(WrBank), 0);
        check("t5_wrready", longint'(WrReady), 0);
        evQ.delete();
        startFrame(16, 8, 1, 1);
        check("t5_valid_cleared", longint'(WrReady), 1);
        mcu();
        waitEv(1, 20, "t5_restart_enable");
        if (evQ.size() >= 1)
            check("t5_restart_ev", evQ[0].x * 100 + evQ[0].y * 10 + evQ[0].b, 0);
        pulseInit();

`ifdef AQ_DJPEG_MCU_SCHED_STATS_EN
        // converter starved for the first 10 cycles of an 8x8 frame
        fdCount = 0;
        convDelay = 3;
        startFrame(8, 8, 1, 1);
        repeat (9) @(negedge clk);
        mcu();
        waitFd(1, 100, "t6_framedone");
        repeat (2) @(negedge clk);
        check("t6_stall", longint'(StallCycles), 10);
        check("t6_blocked", longint'(BlockedCycles), 0);
        convDelay = 0;
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/aq_djpeg_mcu_sched.md
Name: aq_djpeg_mcu_sched

Overview:
- MCU scheduler between the IDCT/upsample writer (producer) and the YCbCr->RGB converter (consumer).
- Owns a two-bank ping-pong MCU buffer and tracks which bank is valid.
- Pulses the converter start (InEnable) with MCU block coordinates, advances X/Y in raster order, and flags frame completion.
- Back-pressures the producer when both banks are full.

Parameters:
- BW, 12, block coordinate width; matches converter InBlockX/InBlockY.
- DW, 16, image dimension width in pixels.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- DataInit  in  1  synchronous soft clear; highest priority after rst.
- FrameStart  in  1  one-cycle pulse; latches geometry when in IDLE, ignored otherwise.
- ImageWidth  in  DW  frame width in pixels; must be nonzero.
- ImageHeight  in  DW  frame height in pixels; must be nonzero.
- SubSamplingW  in  2  horizontal sampling factor, 1 or 2.
- SubSamplingH  in  2  vertical sampling factor, 1 or 2.
- McuDone  in  1  producer finished writing bank WrBank.
- WrBank  out  1  bank the producer writes next.
- WrReady  out  1  WrBank is free for writing.
- ConvEnable  out  1  one-cycle start pulse to the converter.
- ConvBank  out  1  bank the converter reads.
- ConvBlockX  out  BW  MCU column index.
- ConvBlockY  out  BW  MCU row index.
- ConvDone  in  1  converter finished an MCU (its InReadNext).
- Busy  out  1  state != IDLE.
- FrameDone  out  1  one-cycle pulse after the last MCU is consumed.
- Overrun  out  1  sticky: McuDone arrived while WrReady=0.

Behaviour:
- Reset values (rst low) and DataInit: all outputs 0; Valid[1:0]=0; WrBank=RdBank=0; coordinates 0; state IDLE; Overrun cleared.
- Geometry latch, on FrameStart in IDLE:
  - McuCols = W==2 ? (ImageWidth+15)>>4 : (ImageWidth+7)>>3.
  - McuRows = H==2 ? (ImageHeight+15)>>4 : (ImageHeight+7)>>3.
  - Both truncated to BW bits.
  - Latch SubSamplingW/H.
  - Go to WAIT.
- Producer side, active in any non-IDLE state:
  - WrReady = Busy & !Valid[WrBank].
  - McuDone with WrReady: set Valid[WrBank], toggle WrBank next cycle.
  - McuDone without WrReady: ignored, Overrun set.
  - McuDone in IDLE: ignored; Overrun not set.
- States:
  - IDLE: waits for FrameStart.
  - WAIT: if Valid[RdBank] -> ISSUE.
  - ISSUE: ConvEnable=1 for exactly one cycle. ConvBank, ConvBlockX and ConvBlockY are stable from ISSUE until ConvDone. -> RUN.
  - RUN: on ConvDone, clear Valid[RdBank] and toggle RdBank.
    - If BlockX==McuCols-1 and BlockY==McuRows-1: -> DONE.
    - Else if BlockX==McuCols-1: BlockX=0, BlockY+1, -> WAIT.
    - Else BlockX+1, -> WAIT.
  - DONE: FrameDone=1 for one cycle; coordinates reset to 0; Valid and bank pointers retained; -> IDLE.
- Latency: Valid set at edge N -> ConvEnable high in cycle N+2 (WAIT then ISSUE).
- ConvDone outside RUN: ignored.
- Simultaneous McuDone and ConvDone: both take effect in the same cycle. They are necessarily on different banks; the freed bank makes WrReady=1 the following cycle.
- 1x1 frame (McuCols=McuRows=1): single MCU, then DONE.
- DataInit mid-frame: immediate return to IDLE; the converter is expected to be cleared by the same DataInit.
- ConvBank = RdBank.

Optional Feature:
- Macro: AQ_DJPEG_MCU_SCHED_STATS_EN.
- Defined, adds:
  - StallCycles out 32: counts cycles in WAIT with Valid[RdBank]=0 (converter starved).
  - BlockedCycles out 32: counts Busy cycles with WrReady=0 (producer blocked).
  - Both clear on FrameStart accepted and on DataInit, saturate at all-ones, reset 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package aq_djpeg_sched_pkg: state encoding constants (IDLE=0, WAIT=1, ISSUE=2, RUN=3, DONE=4) and the MCU column/row ceiling-division function.
- Sub-module aq_djpeg_pingpong_ctl: the Valid[1:0], WrBank and RdBank bookkeeping with set/clear ports. The scheduler FSM instantiates it.

Test Plan:
- 32x16, W=H=2 (2x1 MCUs): two McuDone spaced 300 cycles apart, ConvDone 256 cycles after each ConvEnable -> ConvEnable coords (0,0) bank0 then (1,0) bank1; one FrameDone; Busy=0 after.
- 24x8, W=H=1 (McuCols=3): producer sends 3 MCUs back-to-back with ConvDone withheld -> WrReady drops after 2nd McuDone; 3rd McuDone sets Overrun=1 and is dropped.
- 17x9, W=1, H=1 -> McuCols=3, McuRows=2; coordinate sequence (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), then FrameDone.
- McuDone and ConvDone in the same cycle -> both banks consistent; next ConvEnable follows 2 cycles later if the other bank is valid.
- DataInit asserted during RUN -> next cycle Busy=0, Valid=0, WrBank=0; a new FrameStart restarts at (0,0).
- With STATS_EN: 8x8 frame, McuDone delayed 10 cycles after FrameStart -> StallCycles=10.
